axis_mesh_link_pmu: RTL and testbench
=====================================

Name: axis_mesh_link_pmu

Overview:
- Parametrised multi-channel AXI-Stream link stage for the XY mesh: N_CH independent router-to-router channels, each with a 2-entry skid buffer breaking every combinational valid/ready path between neighbouring routers.
- Each channel has built-in performance counters (transfers, downstream stalls, upstream backpressure), readable through a registered channel-select port.
- Instantiated on every inter-router link of the next-generation mesh top; N_CH covers bundled request/response networks.

Parameters:
- N_CH, 2, number of independent stream channels (1..16).
- DATA_W, 40, TDATA width per channel.
- CNT_W, 32, performance counter width; counters saturate.
- SEL_W, $clog2(N_CH) minimum 1, width of the channel select.

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- s_tvalid_i  in  N_CH  upstream valid per channel.
- s_tdata_i  in  N_CH*DATA_W  upstream data; channel c occupies bits [c*DATA_W +: DATA_W].
- s_tlast_i  in  N_CH  upstream last.
- s_tready_o  out  N_CH  upstream ready.
- m_tvalid_o  out  N_CH  downstream valid.
- m_tdata_o  out  N_CH*DATA_W  downstream data, same packing as s_tdata_i.
- m_tlast_o  out  N_CH  downstream last.
- m_tready_i  in  N_CH  downstream ready.
- pmu_clear_i  in  1  synchronous clear of all counters.
- pmu_freeze_i  in  1  hold all counters.
- pmu_sel_i  in  SEL_W  channel selected for readout.
- pmu_xfer_o  out  CNT_W  selected channel transfer count.
- pmu_stall_o  out  CNT_W  selected channel downstream-stall count.
- pmu_bp_o  out  CNT_W  selected channel upstream-backpressure count.

Behaviour:
- Reset (asynchronous, ARESETn low):
  - m_tvalid_o = 0; both skid entries empty; s_tready_o = all 1s.
  - All counters and all pmu_*_o = 0.
  - m_tdata_o / m_tlast_o are don't-care but are driven to 0.
- Reset mid-packet drops buffered beats; no recovery is attempted.
- Per-channel skid buffer:
  - Main register plus skid register.
  - s_tready_o[c] = !skid_full[c], registered; no combinational path from m_tready_i.
  - Upstream handshake with main empty or draining: beat goes to main.
  - Upstream handshake while main holds an unaccepted beat: beat goes to skid.
  - Downstream handshake with skid full: skid moves to main, skid empties, s_tready rises next cycle.
  - Simultaneous up and down handshake with skid empty: main is replaced, no bubble.
- Latency: 1 cycle from s handshake to m_tvalid.
- Throughput: 1 beat/cycle per channel with m_tready held high.
- Ordering: beats are never reordered or duplicated; tlast travels with its data.
- Channels are fully independent: no shared arbitration.
- Counters per channel, evaluated each cycle:
  - xfer increments on m_tvalid_o & m_tready_i.
  - stall increments on m_tvalid_o & !m_tready_i.
  - bp increments on s_tvalid_i & !s_tready_o.
  - Each counter saturates at 2^CNT_W-1 with no wrap.
  - Priority: pmu_clear_i > pmu_freeze_i > increment.
  - Clear together with an event yields 0.
  - Freeze also blocks increments but not clear.
- Readout:
  - pmu_*_o are registered copies of the selected channel's counters.
  - 1-cycle latency from a pmu_sel_i change.
  - Values lag counter state by one cycle.
  - pmu_sel_i >= N_CH reads 0 on all three outputs.

Decomposition:
- Shared package axis_mesh_pkg holds:
  - channel-slice helper function for packed data;
  - pmu counter record typedef {xfer, stall, bp};
  - saturating-increment function.
- Sub-module axis_skid_slice: one-channel 2-entry skid buffer, instantiated N_CH times.
- Counters and the readout mux stay in the top.

Test Plan:
- Reset release, N_CH=2: s_tready_o=2'b11, m_tvalid_o=0, pmu outputs 0 → ch0 beat 0x01 presented at cycle 1 appears on m_tdata at cycle 2.
- Streaming with m_tready=1: 8 back-to-back beats 0..7 on ch1 exit in order, one per cycle; xfer=8, stall=0, bp=0.
- Backpressure:
  - m_tready[0]=0 for 4 cycles with s_tvalid high: s_tready[0] drops after the 2nd beat is accepted.
  - Expected counts: stall=4, bp=2.
  - On release, beats drain in order with no loss.
- Saturation, CNT_W=4: 20 transfers give xfer=15; clear with a coincident transfer gives 0; freeze for 3 transfers leaves the count unchanged.
- Channel independence and readout: ch0 stalled while ch1 streams; sel=1 shows ch1 counts one cycle later; sel=3 with N_CH=2 reads 0.
- Async reset asserted mid-stream with skid full: outputs clear immediately with no clock edge; the next beat after release is the first seen downstream.

Source files
------------

// File: rtl/axis_mesh_pkg.sv
// Shared types and helpers for the mesh link stage: lane slicing, the per-channel
// PMU event record and the saturating counter step.
package axis_mesh_pkg;

  localparam int unsigned PMU_CNT_MAX_W = 64;

  typedef logic [PMU_CNT_MAX_W-1:0] pmu_word_t;

  // One cycle's worth of counter events for a channel.
  typedef struct packed {
    logic xfer;
    logic stall;
    logic bp;
  } pmu_evt_t;

  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

  function automatic pmu_word_t cnt_max(input int unsigned width);
    return {PMU_CNT_MAX_W{1'b1}} >> (PMU_CNT_MAX_W - width);
  endfunction

  function automatic pmu_word_t sat_inc(input pmu_word_t value, input pmu_word_t max_value);
    return (value >= max_value) ? max_value : value + pmu_word_t'(1);
  endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// One-channel two-entry skid buffer; s_tready_o is a flop so no combinational
// path runs from m_tready_i back upstream.
module axis_skid_slice #(
  parameter int unsigned DATA_W = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_tvalid_i,
  input  logic [DATA_W-1:0] s_tdata_i,
  input  logic              s_tlast_i,
  output logic              s_tready_o,
  output logic              m_tvalid_o,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic              m_tlast_o,
  input  logic              m_tready_i
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              main_last_q, main_last_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              skid_last_q, skid_last_d;
  logic              up_hs, dn_hs;

  always_comb begin
    up_hs        = s_tvalid_i & ~skid_valid_q;
    dn_hs        = main_valid_q & m_tready_i;
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_last_d  = main_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (skid_valid_q) begin
      // Skid full means main is full too; a downstream take promotes the skid beat.
      if (dn_hs) begin
        main_data_d  = skid_data_q;
        main_last_d  = skid_last_q;
        skid_valid_d = 1'b0;
      end
    end else if (up_hs) begin
      if (!main_valid_q || dn_hs) begin
        main_valid_d = 1'b1;
        main_data_d  = s_tdata_i;
        main_last_d  = s_tlast_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = s_tdata_i;
        skid_last_d  = s_tlast_i;
      end
    end else if (dn_hs) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_last_q  <= main_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
    end
  end

  assign s_tready_o = ~skid_valid_q;
  assign m_tvalid_o = main_valid_q;
  assign m_tdata_o  = main_data_q;
  assign m_tlast_o  = main_last_q;

endmodule

// File: rtl/axis_mesh_link_pmu.sv
// Multi-channel AXI-Stream mesh link stage: one skid slice per channel plus
// saturating transfer/stall/backpressure counters with registered readout.
module axis_mesh_link_pmu
  import axis_mesh_pkg::*;
#(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned DATA_W = 40,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [N_CH-1:0]          s_tvalid_i,
  input  logic [N_CH*DATA_W-1:0]   s_tdata_i,
  input  logic [N_CH-1:0]          s_tlast_i,
  output logic [N_CH-1:0]          s_tready_o,
  output logic [N_CH-1:0]          m_tvalid_o,
  output logic [N_CH*DATA_W-1:0]   m_tdata_o,
  output logic [N_CH-1:0]          m_tlast_o,
  input  logic [N_CH-1:0]          m_tready_i,
  input  logic                     pmu_clear_i,
  input  logic                     pmu_freeze_i,
  input  logic [SEL_W-1:0]         pmu_sel_i,
  output logic [CNT_W-1:0]         pmu_xfer_o,
  output logic [CNT_W-1:0]         pmu_stall_o,
  output logic [CNT_W-1:0]         pmu_bp_o
);

  localparam pmu_word_t CNT_MAX = cnt_max(CNT_W);

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(PMU_CNT_MAX_W'(v), CNT_MAX));
  endfunction

  pmu_evt_t         evt [N_CH];
  logic [CNT_W-1:0] xfer_q [N_CH], xfer_d [N_CH];
  logic [CNT_W-1:0] stall_q [N_CH], stall_d [N_CH];
  logic [CNT_W-1:0] bp_q [N_CH], bp_d [N_CH];
  logic [CNT_W-1:0] rd_xfer_q, rd_xfer_d, rd_stall_q, rd_stall_d, rd_bp_q, rd_bp_d;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    axis_skid_slice #(.DATA_W(DATA_W)) u_slice (
      .clk        (ACLK),
      .rst_n      (ARESETn),
      .s_tvalid_i (s_tvalid_i[c]),
      .s_tdata_i  (s_tdata_i[ch_lsb(c, DATA_W) +: DATA_W]),
      .s_tlast_i  (s_tlast_i[c]),
      .s_tready_o (s_tready_o[c]),
      .m_tvalid_o (m_tvalid_o[c]),
      .m_tdata_o  (m_tdata_o[ch_lsb(c, DATA_W) +: DATA_W]),
      .m_tlast_o  (m_tlast_o[c]),
      .m_tready_i (m_tready_i[c])
    );
  end

  // Clear beats freeze, freeze beats increment.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      evt[c].xfer  = m_tvalid_o[c] & m_tready_i[c];
      evt[c].stall = m_tvalid_o[c] & ~m_tready_i[c];
      evt[c].bp    = s_tvalid_i[c] & ~s_tready_o[c];
      xfer_d[c]    = xfer_q[c];
      stall_d[c]   = stall_q[c];
      bp_d[c]      = bp_q[c];
      if (pmu_clear_i) begin
        xfer_d[c]  = '0;
        stall_d[c] = '0;
        bp_d[c]    = '0;
      end else if (!pmu_freeze_i) begin
        if (evt[c].xfer)  xfer_d[c]  = bump(xfer_q[c]);
        if (evt[c].stall) stall_d[c] = bump(stall_q[c]);
        if (evt[c].bp)    bp_d[c]    = bump(bp_q[c]);
      end
    end
  end

  // Out-of-range selects match no channel and read back as zero.
  always_comb begin
    rd_xfer_d  = '0;
    rd_stall_d = '0;
    rd_bp_d    = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (pmu_sel_i == SEL_W'(c)) begin
        rd_xfer_d  = xfer_q[c];
        rd_stall_d = stall_q[c];
        rd_bp_d    = bp_q[c];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int c = 0; c < N_CH; c++) begin
        xfer_q[c]  <= '0;
        stall_q[c] <= '0;
        bp_q[c]    <= '0;
      end
      rd_xfer_q  <= '0;
      rd_stall_q <= '0;
      rd_bp_q    <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        xfer_q[c]  <= xfer_d[c];
        stall_q[c] <= stall_d[c];
        bp_q[c]    <= bp_d[c];
      end
      rd_xfer_q  <= rd_xfer_d;
      rd_stall_q <= rd_stall_d;
      rd_bp_q    <= rd_bp_d;
    end
  end

  assign pmu_xfer_o  = rd_xfer_q;
  assign pmu_stall_o = rd_stall_q;
  assign pmu_bp_o    = rd_bp_q;

endmodule

// File: tb/tb_axis_mesh_link_pmu.sv
// Directed bench for axis_mesh_link_pmu with N_CH=2, CNT_W=4 so saturation is reachable.
module tb_axis_mesh_link_pmu;

  localparam int N_CH   = 2;
  localparam int DATA_W = 40;
  localparam int CNT_W  = 4;
  localparam int SEL_W  = 2;

  logic                   ACLK = 1'b0;
  logic                   ARESETn;
  logic [N_CH-1:0]        s_tvalid_i;
  logic [N_CH*DATA_W-1:0] s_tdata_i;
  logic [N_CH-1:0]        s_tlast_i;
  logic [N_CH-1:0]        s_tready_o;
  logic [N_CH-1:0]        m_tvalid_o;
  logic [N_CH*DATA_W-1:0] m_tdata_o;
  logic [N_CH-1:0]        m_tlast_o;
  logic [N_CH-1:0]        m_tready_i;
  logic                   pmu_clear_i;
  logic                   pmu_freeze_i;
  logic [SEL_W-1:0]       pmu_sel_i;
  logic [CNT_W-1:0]       pmu_xfer_o, pmu_stall_o, pmu_bp_o;

  int n_vec = 0;
  int n_err = 0;

  axis_mesh_link_pmu #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i), .s_tlast_i(s_tlast_i), .s_tready_o(s_tready_o),
    .m_tvalid_o(m_tvalid_o), .m_tdata_o(m_tdata_o), .m_tlast_o(m_tlast_o), .m_tready_i(m_tready_i),
    .pmu_clear_i(pmu_clear_i), .pmu_freeze_i(pmu_freeze_i), .pmu_sel_i(pmu_sel_i),
    .pmu_xfer_o(pmu_xfer_o), .pmu_stall_o(pmu_stall_o), .pmu_bp_o(pmu_bp_o)
  );

  // Clock / reset
  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Drivers
  task automatic drive(input int c, input logic v, input logic [DATA_W-1:0] d, input logic l);
    s_tvalid_i[c]                  = v;
    s_tdata_i[c*DATA_W +: DATA_W]  = d;
    s_tlast_i[c]                   = l;
  endtask

  task automatic clear_pmu();
    pmu_clear_i = 1'b1;
    step();
    pmu_clear_i = 1'b0;
  endtask

  task automatic read_sel(input logic [SEL_W-1:0] s);
    pmu_sel_i = s;
    step();
  endtask

  function automatic logic [DATA_W-1:0] m_data(input int c);
    return m_tdata_o[c*DATA_W +: DATA_W];
  endfunction

  task automatic test_reset();
    ARESETn = 1'b0; s_tvalid_i = '0; s_tdata_i = '0; s_tlast_i = '0; m_tready_i = '1;
    pmu_clear_i = 1'b0; pmu_freeze_i = 1'b0; pmu_sel_i = '0;
    #3;
    n_vec++; if (s_tready_o !== 2'b11) begin n_err++; $display("FAIL rst_tready: got %b want 11", s_tready_o); end
    n_vec++; if (m_tvalid_o !== 2'b00) begin n_err++; $display("FAIL rst_tvalid: got %b want 00", m_tvalid_o); end
    n_vec++; if (m_tdata_o !== '0) begin n_err++; $display("FAIL rst_tdata: got %h want 0", m_tdata_o); end
    n_vec++; if ({pmu_xfer_o, pmu_stall_o, pmu_bp_o} !== '0) begin n_err++; $display("FAIL rst_pmu: got %h/%h/%h want 0/0/0", pmu_xfer_o, pmu_stall_o, pmu_bp_o); end
    step(); step();
    ARESETn = 1'b1;
    step();
    drive(0, 1'b1, 40'h01, 1'b1);
    n_vec++; if (m_tvalid_o !== 2'b00) begin n_err++; $display("FAIL lat_no_comb: got %b want 00", m_tvalid_o); end
    step();
    drive(0, 1'b0, '0, 1'b0);
    n_vec++; if (m_tvalid_o !== 2'b01 || m_data(0) !== 40'h01 || m_tlast_o[0] !== 1'b1) begin n_err++; $display("FAIL lat_first_beat: got v=%b d=%h l=%b want v=01 d=01 l=1", m_tvalid_o, m_data(0), m_tlast_o[0]); end
    step();
    n_vec++; if (m_tvalid_o !== 2'b00) begin n_err++; $display("FAIL lat_drained: got %b want 00", m_tvalid_o); end
  endtask

  task automatic test_streaming();
    clear_pmu();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1'b1, DATA_W'(i), i == 7);
      step();
      n_vec++; if (m_tvalid_o[1] !== 1'b1 || m_data(1) !== DATA_W'(i) || m_tlast_o[1] !== (i == 7) || s_tready_o[1] !== 1'b1) begin n_err++; $display("FAIL stream_beat%0d: got v=%b d=%h l=%b rdy=%b want v=1 d=%h l=%b rdy=1", i, m_tvalid_o[1], m_data(1), m_tlast_o[1], s_tready_o[1], DATA_W'(i), (i == 7)); end
    end
    drive(1, 1'b0, '0, 1'b0);
    step();
    n_vec++; if (m_tvalid_o[1] !== 1'b0) begin n_err++; $display("FAIL stream_drain: got %b want 0", m_tvalid_o[1]); end
    read_sel(1);
    n_vec++; if (pmu_xfer_o !== 4'd8) begin n_err++; $display("FAIL stream_xfer: got %0d want 8", pmu_xfer_o); end
    n_vec++; if (pmu_stall_o !== 4'd0) begin n_err++; $display("FAIL stream_stall: got %0d want 0", pmu_stall_o); end
    n_vec++; if (pmu_bp_o !== 4'd0) begin n_err++; $display("FAIL stream_bp: got %0d want 0", pmu_bp_o); end
  endtask

  task automatic test_backpressure();
    clear_pmu();
    drive(0, 1'b1, 40'hA0, 1'b0);
    step();
    n_vec++; if (m_data(0) !== 40'hA0 || s_tready_o[0] !== 1'b1) begin n_err++; $display("FAIL bp_first: got d=%h rdy=%b want d=a0 rdy=1", m_data(0), s_tready_o[0]); end
    m_tready_i[0] = 1'b0;
    drive(0, 1'b1, 40'hB1, 1'b0);
    step();
    n_vec++; if (s_tready_o[0] !== 1'b0 || m_tvalid_o[0] !== 1'b1 || m_data(0) !== 40'hA0) begin n_err++; $display("FAIL bp_skid_full: got rdy=%b v=%b d=%h want rdy=0 v=1 d=a0", s_tready_o[0], m_tvalid_o[0], m_data(0)); end
    drive(0, 1'b0, '0, 1'b0);
    step(); step();
    n_vec++; if (s_tready_o[0] !== 1'b0 || m_data(0) !== 40'hA0) begin n_err++; $display("FAIL bp_hold: got rdy=%b d=%h want rdy=0 d=a0", s_tready_o[0], m_data(0)); end
    drive(0, 1'b1, 40'hC2, 1'b1);
    step();
    m_tready_i[0] = 1'b1;
    step();
    n_vec++; if (m_data(0) !== 40'hB1 || s_tready_o[0] !== 1'b1) begin n_err++; $display("FAIL bp_release: got d=%h rdy=%b want d=b1 rdy=1", m_data(0), s_tready_o[0]); end
    step();
    drive(0, 1'b0, '0, 1'b0);
    n_vec++; if (m_tvalid_o[0] !== 1'b1 || m_data(0) !== 40'hC2 || m_tlast_o[0] !== 1'b1) begin n_err++; $display("FAIL bp_third: got v=%b d=%h l=%b want v=1 d=c2 l=1", m_tvalid_o[0], m_data(0), m_tlast_o[0]); end
    step();
    n_vec++; if (m_tvalid_o[0] !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", m_tvalid_o[0]); end
    read_sel(0);
    n_vec++; if (pmu_xfer_o !== 4'd3) begin n_err++; $display("FAIL bp_xfer: got %0d want 3", pmu_xfer_o); end
    n_vec++; if (pmu_stall_o !== 4'd4) begin n_err++; $display("FAIL bp_stall: got %0d want 4", pmu_stall_o); end
    n_vec++; if (pmu_bp_o !== 4'd2) begin n_err++; $display("FAIL bp_bp: got %0d want 2", pmu_bp_o); end
  endtask

  task automatic test_saturation();
    clear_pmu();
    for (int i = 0; i < 20; i++) begin drive(1, 1'b1, DATA_W'(i), 1'b0); step(); end
    drive(1, 1'b0, '0, 1'b0);
    step();
    read_sel(1);
    n_vec++; if (pmu_xfer_o !== 4'd15) begin n_err++; $display("FAIL sat_xfer: got %0d want 15", pmu_xfer_o); end
    drive(1, 1'b1, 40'h55, 1'b0);
    step();
    drive(1, 1'b0, '0, 1'b0);
    pmu_clear_i = 1'b1;
    step();
    pmu_clear_i = 1'b0;
    step();
    read_sel(1);
    n_vec++; if (pmu_xfer_o !== 4'd0) begin n_err++; $display("FAIL sat_clear_evt: got %0d want 0", pmu_xfer_o); end
    for (int i = 0; i < 5; i++) begin drive(1, 1'b1, DATA_W'(i), 1'b0); step(); end
    drive(1, 1'b0, '0, 1'b0);
    step();
    read_sel(1);
    n_vec++; if (pmu_xfer_o !== 4'd5) begin n_err++; $display("FAIL sat_count5: got %0d want 5", pmu_xfer_o); end
    pmu_freeze_i = 1'b1;
    for (int i = 0; i < 3; i++) begin drive(1, 1'b1, DATA_W'(i), 1'b0); step(); end
    drive(1, 1'b0, '0, 1'b0);
    step();
    pmu_freeze_i = 1'b0;
    read_sel(1);
    n_vec++; if (pmu_xfer_o !== 4'd5) begin n_err++; $display("FAIL sat_freeze: got %0d want 5", pmu_xfer_o); end
    pmu_freeze_i = 1'b1;
    pmu_clear_i  = 1'b1;
    step();
    pmu_freeze_i = 1'b0;
    pmu_clear_i  = 1'b0;
    read_sel(1);
    n_vec++; if (pmu_xfer_o !== 4'd0) begin n_err++; $display("FAIL sat_freeze_clear: got %0d want 0", pmu_xfer_o); end
  endtask

  task automatic test_independence();
    clear_pmu();
    pmu_sel_i  = 2'd0;
    m_tready_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      drive(0, i == 0, 40'hAA, 1'b0);
      drive(1, 1'b1, DATA_W'(40'h100 + i), 1'b0);
      step();
      n_vec++; if (m_data(1) !== DATA_W'(40'h100 + i) || m_tvalid_o !== 2'b11 || m_data(0) !== 40'hAA) begin n_err++; $display("FAIL ind_beat%0d: got v=%b d1=%h d0=%h want v=11 d1=%h d0=aa", i, m_tvalid_o, m_data(1), m_data(0), DATA_W'(40'h100 + i)); end
    end
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    step();
    read_sel(1);
    n_vec++; if ({pmu_xfer_o, pmu_stall_o, pmu_bp_o} !== {4'd5, 4'd0, 4'd0}) begin n_err++; $display("FAIL ind_ch1: got %0d/%0d/%0d want 5/0/0", pmu_xfer_o, pmu_stall_o, pmu_bp_o); end
    read_sel(3);
    n_vec++; if ({pmu_xfer_o, pmu_stall_o, pmu_bp_o} !== '0) begin n_err++; $display("FAIL ind_sel3: got %0d/%0d/%0d want 0/0/0", pmu_xfer_o, pmu_stall_o, pmu_bp_o); end
    read_sel(0);
    n_vec++; if ({pmu_xfer_o, pmu_stall_o, pmu_bp_o} !== {4'd0, 4'd7, 4'd0}) begin n_err++; $display("FAIL ind_ch0: got %0d/%0d/%0d want 0/7/0", pmu_xfer_o, pmu_stall_o, pmu_bp_o); end
    m_tready_i = 2'b11;
    step(); step();
    n_vec++; if (m_tvalid_o !== 2'b00) begin n_err++; $display("FAIL ind_drain: got %b want 00", m_tvalid_o); end
  endtask

  task automatic test_async_reset();
    m_tready_i = 2'b00;
    drive(0, 1'b1, 40'hD0, 1'b0); step();
    drive(0, 1'b1, 40'hD1, 1'b0); step();
    drive(0, 1'b0, '0, 1'b0);
    read_sel(0);
    n_vec++; if (s_tready_o[0] !== 1'b0 || pmu_stall_o === 4'd0) begin n_err++; $display("FAIL ar_setup: got rdy=%b stall=%0d want rdy=0 stall!=0", s_tready_o[0], pmu_stall_o); end
    #2;
    ARESETn = 1'b0;
    #1;
    n_vec++; if (m_tvalid_o !== 2'b00 || s_tready_o !== 2'b11) begin n_err++; $display("FAIL ar_stream: got v=%b rdy=%b want v=00 rdy=11", m_tvalid_o, s_tready_o); end
    n_vec++; if ({pmu_xfer_o, pmu_stall_o, pmu_bp_o} !== '0) begin n_err++; $display("FAIL ar_pmu: got %0d/%0d/%0d want 0/0/0", pmu_xfer_o, pmu_stall_o, pmu_bp_o); end
    step();
    ARESETn   = 1'b1;
    m_tready_i = 2'b11;
    step();
    n_vec++; if (m_tvalid_o !== 2'b00) begin n_err++; $display("FAIL ar_no_stale: got %b want 00", m_tvalid_o); end
    drive(0, 1'b1, 40'hE7, 1'b1);
    step();
    drive(0, 1'b0, '0, 1'b0);
    n_vec++; if (m_tvalid_o !== 2'b01 || m_data(0) !== 40'hE7) begin n_err++; $display("FAIL ar_first_after: got v=%b d=%h want v=01 d=e7", m_tvalid_o, m_data(0)); end
    step();
    n_vec++; if (m_tvalid_o !== 2'b00) begin n_err++; $display("FAIL ar_after_drain: got %b want 00", m_tvalid_o); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_saturation();
    test_independence();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
